spi_cmos_bridge: RTL and testbench
==================================

Name: spi_cmos_bridge

Overview:
Parametrised successor to the ESP32-to-CMOS SPI relay. It receives command frames from the ESP32 over a slave SPI link and buffers them in an internal FIFO. It then replays each frame to the image sensor over a master SPI link with programmable SCK rate and CS timing. Unlike the previous block, it runs on one clock domain (the ESP32 SCK is oversampled), validates frame length, and captures sensor read-back data.

Parameters:
FRAME_W, 32, bits per ESP32 frame (MSB first)
CMD_W, 27, low bits of each frame forwarded to the sensor (CMD_W <= FRAME_W)
RW_BIT, 16, index within CMD_W; 1 = read command
RD_W, 16, read-back bits captured from the last RD_W sensor SCK cycles (RD_W <= CMD_W)
FIFO_DEPTH, 16, command FIFO entries (power of 2, >= 2)
CLK_DIV, 5, sys_clk cycles per sck_out half-period (>= 2)
CS_GAP, 4, minimum sys_clk cycles cs_n_out stays high between transfers (>= 1)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  reset, synchronous, active-low
sck_in  in  1  ESP32 SCK, asynchronous
cs_n_in  in  1  ESP32 chip select, active-low, asynchronous
mosi_in  in  1  ESP32 data to FPGA
ready  in  1  ESP32 permission to start sensor transfers
sck_out  out  1  sensor SCK, idle low (mode 0)
cs_n_out  out  1  sensor chip select, active-low
mosi  out  1  data to sensor
miso  in  1  data from sensor
rd_data  out  RD_W  last captured read-back word
rd_valid  out  1  one-cycle pulse when rd_data updates
busy  out  1  high while cs_n_out low or during the gap
fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
wr_full  out  1  FIFO full
rd_empty  out  1  FIFO empty
frame_err  out  1  one-cycle pulse when a malformed frame is dropped
ovf_err  out  1  one-cycle pulse when a valid frame is dropped because the FIFO is full

Behaviour:
- Reset (sync, sys_rst_n=0 at a sys_clk edge):
  - sck_out=0, cs_n_out=1, mosi=0, rd_data=0, rd_valid=0, busy=0, frame_err=0, ovf_err=0.
  - FIFO emptied: fifo_level=0, rd_empty=1, wr_full=0.
  - Master FSM goes to IDLE; any partial slave frame is discarded.
  - Reset mid-transfer aborts immediately; cs_n_out is high on the next edge.
- Slave input synchronisation:
  - sck_in, cs_n_in and mosi_in each pass through a 2-FF synchroniser plus one history FF.
  - Requirement: sck_in high and low phases are each >= 3 sys_clk cycles.
- Slave reception:
  - On each synchronised sck_in rising edge with cs_n_in low: shift mosi_in into a FRAME_W register (MSB first) and increment a bit counter that saturates at FRAME_W+1.
  - Synchronised cs_n_in falling edge clears the counter.
  - Synchronised cs_n_in rising edge with count == FRAME_W: push frame[CMD_W-1:0] into the FIFO.
  - Any other count at the rising edge: drop the frame and pulse frame_err; this covers counts of 0 through FRAME_W-1 and the over-long saturated value.
  - After reset, frames are accepted only after cs_n_in has first been seen high.
- FIFO:
  - Push is accepted if not full, or if a pop occurs in the same cycle.
  - A push that is not accepted pulses ovf_err; FIFO contents are unchanged.
  - fifo_level, wr_full and rd_empty are registered and reflect the push/pop of the previous cycle.
- Master FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: when ready=1 and rd_empty=0, pop the FIFO head into the shift register. Next cycle: cs_n_out=0, mosi=shift MSB, go to SETUP.
  - SETUP: hold for CLK_DIV cycles with sck_out=0, then go to SHIFT.
  - SHIFT: sck_out toggles every CLK_DIV cycles.
    - Rising edge: sample miso into the capture register.
    - Falling edge: present the next bit on mosi.
    - After CMD_W rising edges and the following falling edge, go to HOLD.
  - HOLD: CLK_DIV cycles with sck_out=0 and cs_n_out=0. Then cs_n_out=1, mosi=0, go to GAP.
    - If the sent word's bit RW_BIT=1: on HOLD exit, rd_data is loaded with the last RD_W sampled bits and rd_valid pulses for 1 cycle.
  - GAP: CS_GAP cycles, then IDLE.
  - cs_n_out is low for exactly CLK_DIV*(2*CMD_W+2) cycles per transfer.
- ready deasserted mid-transfer: the current transfer completes; no new pop occurs until ready=1.
- Simultaneous events:
  - A slave push and a master pop in the same cycle are both applied.
  - A push into an empty FIFO cannot be popped in the same cycle; the earliest pop is the next cycle.
- busy=1 from the pop cycle through the last GAP cycle.

Test Plan:
- Single write: ESP32 sends 0x0012_3456 (32 bits) with ready=1 -> sensor sees 27 bits 0x0123456 MSB first; cs_n_out low 280 cycles; sck_out period 10 cycles; rd_valid stays 0.
- Read command: frame with bit16=1; sensor drives miso with pattern 0xA5C3 over the last 16 SCK cycles -> rd_data=0xA5C3 and rd_valid pulses once, at the cycle cs_n_out rises.
- Malformed frames: cs_n_in rises after 31 bits, then after 33 bits -> two frame_err pulses; fifo_level stays 0; no sensor activity.
- Overflow: ready=0, send 17 frames -> fifo_level=16, wr_full=1, exactly one ovf_err pulse. Raise ready -> 16 transfers in push order, each separated by >= 4 cycles of cs_n_out high.
- Flow control: deassert ready during bit 10 of a transfer -> that transfer completes all 27 bits; no further cs_n_out assertion until ready=1.
- Reset mid-transfer: assert sys_rst_n=0 for 1 cycle during SHIFT -> next edge cs_n_out=1, sck_out=0, fifo_level=0; a subsequent valid frame transfers normally.

Source files
------------

// File: rtl/spi_cmos_bridge.sv
// ESP32 slave-SPI frames are oversampled into a command FIFO and replayed to the sensor over master SPI; read-back is captured.
// Latency: push 3 sys_clk after the ESP32 CS rises; sensor CS falls 1 cycle after the pop; CS stays low CLK_DIV*(2*CMD_W+2) cycles.
// Backpressure: ready gates only new pops (a running transfer always completes); a push into a full FIFO is dropped with ovf_err.
module spi_cmos_bridge #(
  parameter int FRAME_W    = 32,
  parameter int CMD_W      = 27,
  parameter int RW_BIT     = 16,
  parameter int RD_W       = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 5,
  parameter int CS_GAP     = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        sck_in,
  input  logic                        cs_n_in,
  input  logic                        mosi_in,
  input  logic                        ready,
  output logic                        sck_out,
  output logic                        cs_n_out,
  output logic                        mosi,
  input  logic                        miso,
  output logic [RD_W-1:0]             rd_data,
  output logic                        rd_valid,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        wr_full,
  output logic                        rd_empty,
  output logic                        frame_err,
  output logic                        ovf_err
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BCW  = $clog2(FRAME_W + 2);
  localparam int SBW  = $clog2(CMD_W + 1);
  localparam int CNTW = $clog2(((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP) + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  // ---------------- slave side ----------------
  logic [2:0]       r_sck_s, r_cs_s, r_mosi_s;
  logic             r_armed, r_frame_err;
  logic [BCW-1:0]   r_bitcnt;
  // Only the last CMD_W bits of a frame are ever forwarded, so the shifter keeps just those.
  logic [CMD_W-1:0] r_frame;
  logic             w_sck_rise, w_cs_fall, w_cs_rise, w_push;

  // Two synchroniser stages plus one history stage per async input; bit 1 is the synced value, bit 2 the history.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_sck_s  <= '0;
      r_cs_s   <= '0;
      r_mosi_s <= '0;
    end else begin
      r_sck_s  <= {r_sck_s[1:0], sck_in};
      r_cs_s   <= {r_cs_s[1:0], cs_n_in};
      r_mosi_s <= {r_mosi_s[1:0], mosi_in};
    end
  end

  assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
  assign w_cs_fall  = ~r_cs_s[1] & r_cs_s[2];
  assign w_cs_rise  = r_cs_s[1] & ~r_cs_s[2];
  assign w_push     = r_armed & w_cs_rise & (r_bitcnt == BCW'(FRAME_W));

  // Frame reception; nothing counts until CS has been seen stably high, so a frame cut by reset is never half-accepted.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_armed     <= 1'b0;
      r_bitcnt    <= '0;
      r_frame     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (r_cs_s[1] && r_cs_s[2]) r_armed <= 1'b1;
      if (r_armed) begin
        if (w_cs_fall) begin
          r_bitcnt <= '0;
        end else if (w_sck_rise && !r_cs_s[1]) begin
          // mosi history tap is one cycle older than the sck edge, well inside the stable window
          r_frame <= {r_frame[CMD_W-2:0], r_mosi_s[2]};
          if (r_bitcnt != BCW'(FRAME_W + 1)) r_bitcnt <= r_bitcnt + BCW'(1);
        end
        if (w_cs_rise && (r_bitcnt != BCW'(FRAME_W))) r_frame_err <= 1'b1;
      end
    end
  end

  // ---------------- command FIFO ----------------
  logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_level, w_level_nxt;
  logic             r_full, r_empty, r_ovf;
  logic             w_pop, w_push_ok;
  logic [CMD_W-1:0] w_head;

  assign w_push_ok = w_push & (~r_full | w_pop);
  assign w_head    = r_mem[r_rptr];

  // Storage array; only the pointers need reset.
  always_ff @(posedge sys_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_frame;
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push_ok && !w_pop)      w_level_nxt = r_level + (AW+1)'(1);
    else if (!w_push_ok && w_pop) w_level_nxt = r_level - (AW+1)'(1);
  end

  // Pointers and registered status flags.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == (AW+1)'(FIFO_DEPTH));
      r_empty <= (w_level_nxt == '0);
      r_ovf   <= w_push & ~w_push_ok;
    end
  end

  // ---------------- master side ----------------
  state_t           r_state, w_state_nxt;
  logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
  logic [SBW-1:0]   r_bits, w_bits_nxt;
  logic [CMD_W-1:0] r_shift, w_shift_nxt;
  logic [RD_W-1:0]  r_cap, w_cap_nxt, r_rd_data, w_rd_data_nxt;
  logic             r_rw, w_rw_nxt, r_sck, w_sck_nxt, r_cs_n, w_cs_n_nxt;
  logic             r_mosi, w_mosi_nxt, r_rd_valid, w_rd_valid_nxt;
  logic             w_div_last;

  assign w_div_last = (r_cnt == CNTW'(CLK_DIV - 1));

  // Master state register and datapath registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bits     <= '0;
      r_shift    <= '0;
      r_cap      <= '0;
      r_rw       <= 1'b0;
      r_sck      <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bits     <= w_bits_nxt;
      r_shift    <= w_shift_nxt;
      r_cap      <= w_cap_nxt;
      r_rw       <= w_rw_nxt;
      r_sck      <= w_sck_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_mosi     <= w_mosi_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

  // Next-state and output decode; each sck half-period lasts CLK_DIV cycles, SHIFT holds CMD_W full sck periods.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bits_nxt     = r_bits;
    w_shift_nxt    = r_shift;
    w_cap_nxt      = r_cap;
    w_rw_nxt       = r_rw;
    w_sck_nxt      = r_sck;
    w_cs_n_nxt     = r_cs_n;
    w_mosi_nxt     = r_mosi;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ready && !r_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_rw_nxt    = w_head[RW_BIT];
          w_cs_n_nxt  = 1'b0;
          w_mosi_nxt  = w_head[CMD_W-1];
          w_cnt_nxt   = '0;
          w_bits_nxt  = '0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_div_last) begin
          w_cnt_nxt   = '0;
          w_sck_nxt   = 1'b1;
          w_cap_nxt   = {r_cap[RD_W-2:0], miso};
          w_bits_nxt  = r_bits + SBW'(1);
          w_state_nxt = S_SHIFT;
        end else begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
      end
      S_SHIFT: begin
        if (w_div_last) begin
          w_cnt_nxt = '0;
          if (r_sck) begin
            w_sck_nxt   = 1'b0;
            w_mosi_nxt  = r_shift[CMD_W-2];
            w_shift_nxt = {r_shift[CMD_W-2:0], 1'b0};
          end else if (r_bits == SBW'(CMD_W)) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_sck_nxt  = 1'b1;
            w_cap_nxt  = {r_cap[RD_W-2:0], miso};
            w_bits_nxt = r_bits + SBW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
      end
      S_HOLD: begin
        if (w_div_last) begin
          w_cnt_nxt   = '0;
          w_cs_n_nxt  = 1'b1;
          w_mosi_nxt  = 1'b0;
          w_state_nxt = S_GAP;
          if (r_rw) begin
            w_rd_data_nxt  = r_cap;
            w_rd_valid_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == CNTW'(CS_GAP - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sck_out    = r_sck;
  assign cs_n_out   = r_cs_n;
  assign mosi       = r_mosi;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign busy       = (r_state != S_IDLE) | w_pop;
  assign fifo_level = r_level;
  assign wr_full    = r_full;
  assign rd_empty   = r_empty;
  assign frame_err  = r_frame_err;
  assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_spi_cmos_bridge.sv
// Testbench for spi_cmos_bridge: ESP32 frame driver, sensor-side monitor/responder, table vectors, corner sequences, random frames.
// Latency: not applicable.
// Backpressure: drives ready to stall and release the master side.
module tb_spi_cmos_bridge;
  localparam int FRAME_W = 32, CMD_W = 27, RW_BIT = 16, RD_W = 16;
  localparam int FIFO_DEPTH = 16, CLK_DIV = 5, CS_GAP = 4;
  localparam int XFER_LOW = 280;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0, sck_in = 1'b0, cs_n_in = 1'b1, mosi_in = 1'b0;
  logic ready = 1'b0, miso = 1'b0;
  logic sck_out, cs_n_out, mosi, rd_valid, busy, wr_full, rd_empty, frame_err, ovf_err;
  logic [RD_W-1:0] rd_data;
  logic [4:0] fifo_level;

  always #10 sys_clk = ~sys_clk;

  spi_cmos_bridge #(.FRAME_W(FRAME_W), .CMD_W(CMD_W), .RW_BIT(RW_BIT), .RD_W(RD_W),
                    .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sck_in(sck_in), .cs_n_in(cs_n_in),
    .mosi_in(mosi_in), .ready(ready), .sck_out(sck_out), .cs_n_out(cs_n_out), .mosi(mosi),
    .miso(miso), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .fifo_level(fifo_level),
    .wr_full(wr_full), .rd_empty(rd_empty), .frame_err(frame_err), .ovf_err(ovf_err));

  int n_err = 0, n_chk = 0;

  typedef struct {
    logic [CMD_W-1:0] word;
    int               lowlen;
    int               rises;
    logic             rdv;
    logic [RD_W-1:0]  rdd;
  } xfer_t;
  xfer_t obs[$];

  typedef struct {
    logic [63:0]      data;
    int               nbits;
    logic [RD_W-1:0]  resp;
    int               exp_n;
    logic [CMD_W-1:0] exp_word;
    int               exp_ferr;
    int               exp_rdv;
    logic [RD_W-1:0]  exp_rdd;
  } vec_t;
  vec_t tbl [5];

  // sensor monitor state
  int mon_rises = 0, rdv_cnt = 0, ferr_cnt = 0, ovf_cnt = 0, cyc = 0;
  int min_gap = 1000000, per_min = 1000000, per_max = 0;
  int lowlen = 0, highlen = 0, last_rise = 0;
  bit have_prev = 0;
  logic prev_cs = 1'b1, prev_sck = 1'b0;
  logic [CMD_W-1:0] cur_word = '0;
  logic [RD_W-1:0] sens_resp = '0;

  // Sensor drives its response on the last RD_W of the CMD_W clocks, MSB first.
  function automatic logic resp_bit(input int k);
    int j;
    j = k - (CMD_W - RD_W);
    if (k < CMD_W && j >= 0) return sens_resp[RD_W-1-j];
    return 1'b0;
  endfunction

  // Sensor-side observer: records each CS-low window and answers on miso.
  always @(negedge sys_clk) begin
    cyc++;
    if (!cs_n_out) begin
      if (prev_cs) begin
        mon_rises = 0;
        cur_word  = '0;
        lowlen    = 0;
        if (have_prev && highlen < min_gap) min_gap = highlen;
      end
      lowlen++;
      if (sck_out && !prev_sck) begin
        if (mon_rises > 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        mon_rises++;
        cur_word = {cur_word[CMD_W-2:0], mosi};
      end
      if (!sck_out) miso = resp_bit(mon_rises);
    end else begin
      if (!prev_cs) begin
        obs.push_back('{cur_word, lowlen, mon_rises, rd_valid, rd_data});
        have_prev = 1;
        highlen   = 0;
      end
      highlen++;
      miso = 1'b0;
    end
    if (rd_valid)  rdv_cnt++;
    if (frame_err) ferr_cnt++;
    if (ovf_err)   ovf_cnt++;
    prev_cs  = cs_n_out;
    prev_sck = sck_out;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // ESP32 mode-0 master: data changes while sck is low, nb bits MSB first, h cycles per half-period.
  task automatic send(input logic [63:0] d, input int nb, input int h);
    cs_n_in = 1'b0;
    cycles(h);
    for (int i = 0; i < nb; i++) begin
      mosi_in = d[nb-1-i];
      cycles(h);
      sck_in = 1'b1;
      cycles(h);
      sck_in = 1'b0;
    end
    cycles(h);
    cs_n_in = 1'b1;
    mosi_in = 1'b0;
    cycles(2*h + 2);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    cycles(8);
    while (!(busy == 1'b0 && rd_empty == 1'b1) && n < budget) begin
      cycles(1);
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", nm, budget);
    end
  endtask

  task automatic wait_rises(input int k, input int budget, input string nm);
    int n;
    n = 0;
    while (!(cs_n_out == 1'b0 && mon_rises == k) && n < budget) begin
      cycles(1);
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: sck rise %0d not seen within %0d cycles", nm, k, budget);
    end
  endtask

  initial begin
    int n0, f0, r0, o0, nb, h, ferr_exp;
    logic [63:0] d;
    logic [CMD_W-1:0] words[$];
    logic [CMD_W-1:0] exp_q[$];

    //           data             nbits resp      n  word          ferr rdv rdd
    tbl[0] = '{64'h0000_0000_0012_3456, 32, 16'hFFFF, 1, 27'h0123456, 0, 0, 16'h0000};
    tbl[1] = '{64'h0000_0000_0001_ABCD, 32, 16'hA5C3, 1, 27'h001ABCD, 0, 1, 16'hA5C3};
    tbl[2] = '{64'h0000_0000_1234_5678, 31, 16'h0000, 0, 27'h0000000, 1, 0, 16'h0000};
    tbl[3] = '{64'h0000_0001_2345_6789, 33, 16'h0000, 0, 27'h0000000, 1, 0, 16'h0000};
    tbl[4] = '{64'h0000_0000_FFFF_FFFF, 32, 16'h5A3C, 1, 27'h7FFFFFF, 0, 1, 16'h5A3C};

    // reset state
    cycles(4);
    sys_rst_n = 1'b1;
    cycles(3);
    chk("rst_ctrl_outs", {sck_out, cs_n_out, mosi, rd_valid, busy, frame_err, ovf_err}, 64'b0100000);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_rd_empty", rd_empty, 1);
    chk("rst_wr_full", wr_full, 0);

    // table-driven single frames
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sens_resp = tbl[i].resp;
      n0 = obs.size(); f0 = ferr_cnt; r0 = rdv_cnt;
      send(tbl[i].data, tbl[i].nbits, 3);
      wait_idle(2000, $sformatf("tbl%0d_idle", i));
      chk($sformatf("tbl%0d_nxfer", i), obs.size() - n0, tbl[i].exp_n);
      if (tbl[i].exp_n == 1 && obs.size() == n0 + 1) begin
        chk($sformatf("tbl%0d_word", i), obs[n0].word, tbl[i].exp_word);
        chk($sformatf("tbl%0d_cs_low", i), obs[n0].lowlen, XFER_LOW);
        chk($sformatf("tbl%0d_sck_rises", i), obs[n0].rises, CMD_W);
        chk($sformatf("tbl%0d_rdv_at_cs_rise", i), obs[n0].rdv, tbl[i].exp_rdv);
        if (tbl[i].exp_rdv == 1) chk($sformatf("tbl%0d_rd_data", i), obs[n0].rdd, tbl[i].exp_rdd);
      end
      chk($sformatf("tbl%0d_frame_err", i), ferr_cnt - f0, tbl[i].exp_ferr);
      chk($sformatf("tbl%0d_rd_valid_pulses", i), rdv_cnt - r0, tbl[i].exp_rdv);
      chk($sformatf("tbl%0d_fifo_level", i), fifo_level, 0);
    end
    chk("sck_period_min", per_min, 2*CLK_DIV);
    chk("sck_period_max", per_max, 2*CLK_DIV);

    // overflow: 17 frames while stalled, then drain in order
    ready = 1'b0;
    o0 = ovf_cnt; n0 = obs.size();
    for (int i = 0; i < 17; i++) begin
      d = {32'h0, $urandom};
      words.push_back(d[CMD_W-1:0]);
      send(d, 32, 3);
    end
    cycles(10);
    chk("ovf_fifo_level", fifo_level, FIFO_DEPTH);
    chk("ovf_wr_full", wr_full, 1);
    chk("ovf_pulses", ovf_cnt - o0, 1);
    chk("ovf_no_xfer_while_stalled", obs.size() - n0, 0);
    min_gap = 1000000;
    ready = 1'b1;
    wait_idle(16*320, "ovf_drain");
    chk("ovf_drain_count", obs.size() - n0, 16);
    for (int k = 0; k < 16 && n0 + k < obs.size(); k++)
      chk($sformatf("ovf_order%0d", k), obs[n0+k].word, words[k]);
    chk("ovf_cs_gap_ok", min_gap >= CS_GAP, 1);

    // flow control: drop ready during bit 10
    ready = 1'b0;
    n0 = obs.size();
    send(64'h0000_1111, 32, 3);
    send(64'h0001_2222, 32, 3);
    ready = 1'b1;
    wait_rises(10, 2000, "flow_bit10");
    ready = 1'b0;
    cycles(700);
    chk("flow_one_xfer", obs.size() - n0, 1);
    if (obs.size() > n0) begin
      chk("flow_word_a", obs[n0].word, 27'h0001111);
      chk("flow_rises_a", obs[n0].rises, CMD_W);
    end
    chk("flow_level_held", fifo_level, 1);
    chk("flow_cs_high", cs_n_out, 1);
    ready = 1'b1;
    wait_idle(2000, "flow_resume");
    chk("flow_two_xfers", obs.size() - n0, 2);
    if (obs.size() > n0 + 1) chk("flow_word_b", obs[n0+1].word, 27'h0012222);

    // reset during SHIFT
    ready = 1'b0;
    send(64'h0333_3333, 32, 3);
    send(64'h0444_4444, 32, 3);
    ready = 1'b1;
    wait_rises(5, 2000, "rst_mid_wait");
    sys_rst_n = 1'b0;
    cycles(1);
    sys_rst_n = 1'b1;
    chk("rst_mid_cs_n", cs_n_out, 1);
    chk("rst_mid_sck", sck_out, 0);
    chk("rst_mid_level", fifo_level, 0);
    cycles(10);
    n0 = obs.size(); f0 = ferr_cnt;
    send(64'h0765_4321, 32, 4);
    wait_idle(2000, "rst_after_idle");
    chk("rst_after_nxfer", obs.size() - n0, 1);
    if (obs.size() > n0) begin
      chk("rst_after_word", obs[n0].word, 27'h7654321);
      chk("rst_after_cs_low", obs[n0].lowlen, XFER_LOW);
    end
    chk("rst_after_frame_err", ferr_cnt - f0, 0);

    // random frames against a queue model
    sens_resp = RD_W'($urandom);
    n0 = obs.size(); f0 = ferr_cnt; o0 = ovf_cnt; ferr_exp = 0;
    for (int i = 0; i < 10; i++) begin
      d  = {$urandom, $urandom};
      nb = 32;
      if ($urandom_range(0, 9) >= 7) begin
        nb = int'($urandom_range(0, 34));
        if (nb >= 32) nb++;
      end
      h = int'($urandom_range(3, 6));
      ready = ($urandom_range(0, 3) != 0);
      send(d, nb, h);
      if (nb == FRAME_W) exp_q.push_back(d[CMD_W-1:0]);
      else ferr_exp++;
    end
    ready = 1'b1;
    wait_idle(12*320, "rand_drain");
    chk("rand_nxfer", obs.size() - n0, exp_q.size());
    for (int k = 0; k < exp_q.size() && n0 + k < obs.size(); k++) begin
      chk($sformatf("rand%0d_word", k), obs[n0+k].word, exp_q[k]);
      chk($sformatf("rand%0d_cs_low", k), obs[n0+k].lowlen, XFER_LOW);
      chk($sformatf("rand%0d_rdv", k), obs[n0+k].rdv, exp_q[k][RW_BIT]);
      if (exp_q[k][RW_BIT]) chk($sformatf("rand%0d_rd_data", k), obs[n0+k].rdd, sens_resp);
    end
    chk("rand_frame_err", ferr_cnt - f0, ferr_exp);
    chk("rand_ovf", ovf_cnt - o0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
